// File: rtl/cci_mpf_edge_fiu_c0_buf.sv
// Last MPF stage on the C0 read-request path: FIFO-buffers requests, strips the
// MPF header extension and issues base requests to the FIU when it has room.
module cci_mpf_edge_fiu_c0_buf #(
    parameter int unsigned N_ENTRIES = 16,
    parameter int unsigned THRESHOLD = 8,
    // Request layout: {hdr.ext[2:0], hdr.base[61:0], rdValid}
    // hdr.base = {req_type[3:0], address[41:0], mdata[15:0]}
    // hdr.ext bit 0 = addrIsVirtual
    localparam int unsigned BASE_HDR_W = 62,
    localparam int unsigned EXT_W      = 3,
    localparam int unsigned MPF_W      = 1 + BASE_HDR_W + EXT_W,
    localparam int unsigned CCI_W      = 1 + BASE_HDR_W,
    localparam int unsigned PTR_W      = $clog2(N_ENTRIES),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MPF_W-1:0] afu_c0Tx,
    output logic             afu_c0TxAlmFull,
    output logic [CCI_W-1:0] fiu_c0Tx,
    input  logic             fiu_c0TxAlmFull,
    output logic             err_virtAddr,
    output logic             err_overflow,
    output logic [15:0]      drop_count,
    output logic [CNT_W-1:0] occupancy
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ENTRIES);
    localparam logic [CNT_W-1:0] ALM_CNT  = CNT_W'(N_ENTRIES - THRESHOLD);

    // Request field extraction
    logic                  in_valid;
    logic                  in_virtual;
    logic [BASE_HDR_W-1:0] in_base_hdr;

    assign in_valid    = afu_c0Tx[0];
    assign in_base_hdr = afu_c0Tx[BASE_HDR_W:1];
    assign in_virtual  = afu_c0Tx[BASE_HDR_W+1];

    // FIFO storage and state
    logic [BASE_HDR_W-1:0] mem [N_ENTRIES];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [CCI_W-1:0]      out_q, out_d;
    logic                  alm_full_q, alm_full_d;
    logic                  err_va_q, err_va_d;
    logic                  err_ovf_q, err_ovf_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    // Per-cycle decisions
    logic deq;
    logic full;
    logic enq;
    logic va_drop;
    logic ovf_drop;

    always_comb begin
        deq      = (occ_q != '0) && !fiu_c0TxAlmFull;
        // A dequeue in the same cycle frees the slot, so full only counts without one.
        full     = (occ_q == FULL_CNT) && !deq;
        va_drop  = in_valid && in_virtual;
        ovf_drop = in_valid && !in_virtual && full;
        enq      = in_valid && !in_virtual && !full;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_comb begin
        out_d = '0;
        if (deq) begin
            out_d = {mem[rd_ptr_q], 1'b1};
        end
    end

    always_comb begin
        alm_full_d = (occ_d >= ALM_CNT);
        err_va_d   = err_va_q | va_drop;
        err_ovf_d  = err_ovf_q | ovf_drop;
        drop_cnt_d = drop_cnt_q;
        if ((va_drop || ovf_drop) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            out_q      <= '0;
            alm_full_q <= 1'b0;
            err_va_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            alm_full_q <= alm_full_d;
            err_va_q   <= err_va_d;
            err_ovf_q  <= err_ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= in_base_hdr;
        end
    end

    assign fiu_c0Tx        = out_q;
    assign afu_c0TxAlmFull = alm_full_q;
    assign err_virtAddr    = err_va_q;
    assign err_overflow    = err_ovf_q;
    assign drop_count      = drop_cnt_q;
    assign occupancy       = occ_q;

endmodule

// File: tb/tb_cci_mpf_edge_fiu_c0_buf.sv
// Directed bench for cci_mpf_edge_fiu_c0_buf (N_ENTRIES=16, THRESHOLD=8) with
// hand-computed expectations checked by immediate assertions.
module tb_cci_mpf_edge_fiu_c0_buf;

    logic        clk;
    logic        reset;
    logic [65:0] afu_c0Tx;
    logic        afu_c0TxAlmFull;
    logic [62:0] fiu_c0Tx;
    logic        fiu_c0TxAlmFull;
    logic        err_virtAddr;
    logic        err_overflow;
    logic [15:0] drop_count;
    logic [4:0]  occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    cci_mpf_edge_fiu_c0_buf #(
        .N_ENTRIES(16),
        .THRESHOLD(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .afu_c0Tx       (afu_c0Tx),
        .afu_c0TxAlmFull(afu_c0TxAlmFull),
        .fiu_c0Tx       (fiu_c0Tx),
        .fiu_c0TxAlmFull(fiu_c0TxAlmFull),
        .err_virtAddr   (err_virtAddr),
        .err_overflow   (err_overflow),
        .drop_count     (drop_count),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [65:0] mk_req(input logic va, input logic [3:0] rt,
                                           input logic [41:0] addr, input logic [15:0] md);
        return {2'b00, va, rt, addr, md, 1'b1};
    endfunction

    function automatic logic [62:0] mk_out(input logic [3:0] rt, input logic [41:0] addr,
                                           input logic [15:0] md);
        return {rt, addr, md, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        afu_c0Tx        = '0;
        fiu_c0TxAlmFull = 1'b0;
        #12;
        check("reset_occ", 128'(occupancy), 128'd0);
        check("reset_fiu", 128'(fiu_c0Tx), 128'd0);
        check("reset_almfull", 128'(afu_c0TxAlmFull), 128'd0);
        check("reset_errs", 128'({err_virtAddr, err_overflow}), 128'd0);
        check("reset_drops", 128'(drop_count), 128'd0);
        reset = 1'b0;
        step();

        // Single PA read
        afu_c0Tx = mk_req(1'b0, 4'h1, 42'h1234, 16'h5);
        step();
        afu_c0Tx = '0;
        check("pa_occ_after_enq", 128'(occupancy), 128'd1);
        check("pa_not_yet_valid", 128'(fiu_c0Tx[0]), 128'd0);
        step();
        check("pa_out", 128'(fiu_c0Tx), 128'(mk_out(4'h1, 42'h1234, 16'h5)));
        check("pa_occ_drained", 128'(occupancy), 128'd0);
        step();
        check("pa_out_invalid", 128'(fiu_c0Tx), 128'd0);

        // VA read is dropped
        afu_c0Tx = mk_req(1'b1, 4'h1, 42'h777, 16'h9);
        step();
        afu_c0Tx = '0;
        check("va_err", 128'(err_virtAddr), 128'd1);
        check("va_drops", 128'(drop_count), 128'd1);
        check("va_occ", 128'(occupancy), 128'd0);
        step();
        check("va_no_out", 128'(fiu_c0Tx[0]), 128'd0);
        check("va_no_ovf", 128'(err_overflow), 128'd0);

        // Almost-full threshold with FIU stalled
        fiu_c0TxAlmFull = 1'b1;
        for (int i = 0; i < 8; i++) begin
            afu_c0Tx = mk_req(1'b0, 4'h1, 42'h2000 + 42'(i), 16'(i));
            step();
            if (i == 6) check("alm_before_8th", 128'(afu_c0TxAlmFull), 128'd0);
        end
        afu_c0Tx = '0;
        check("alm_after_8th", 128'(afu_c0TxAlmFull), 128'd1);
        check("alm_occ8", 128'(occupancy), 128'd8);
        step();
        check("alm_stall_no_out", 128'(fiu_c0Tx[0]), 128'd0);
        fiu_c0TxAlmFull = 1'b0;
        step();
        check("alm_occ7", 128'(occupancy), 128'd7);
        check("alm_dropped", 128'(afu_c0TxAlmFull), 128'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            check($sformatf("alm_order_%0d", i), 128'(fiu_c0Tx),
                  128'(mk_out(4'h1, 42'h2000 + 42'(i), 16'(i))));
        end
        step();
        check("alm_drained_occ", 128'(occupancy), 128'd0);
        check("alm_drained_out", 128'(fiu_c0Tx[0]), 128'd0);

        // Overflow: 17 requests into a stalled 16-entry FIFO
        fiu_c0TxAlmFull = 1'b1;
        for (int i = 0; i < 17; i++) begin
            afu_c0Tx = mk_req(1'b0, 4'h2, 42'h3000 + 42'(i), 16'h100 + 16'(i));
            step();
        end
        afu_c0Tx = '0;
        check("ovf_occ", 128'(occupancy), 128'd16);
        check("ovf_err", 128'(err_overflow), 128'd1);
        check("ovf_drops", 128'(drop_count), 128'd2);
        check("ovf_almfull", 128'(afu_c0TxAlmFull), 128'd1);

        // Enqueue at full while the FIU is ready: accepted, occupancy unchanged
        fiu_c0TxAlmFull = 1'b0;
        afu_c0Tx = mk_req(1'b0, 4'h2, 42'h3FFF, 16'h200);
        step();
        afu_c0Tx = '0;
        check("full_rw_occ", 128'(occupancy), 128'd16);
        check("full_rw_drops", 128'(drop_count), 128'd2);
        check("full_rw_out0", 128'(fiu_c0Tx), 128'(mk_out(4'h2, 42'h3000, 16'h100)));
        for (int i = 1; i < 16; i++) begin
            step();
            check($sformatf("ovf_order_%0d", i), 128'(fiu_c0Tx),
                  128'(mk_out(4'h2, 42'h3000 + 42'(i), 16'h100 + 16'(i))));
        end
        step();
        check("full_rw_last", 128'(fiu_c0Tx), 128'(mk_out(4'h2, 42'h3FFF, 16'h200)));
        check("full_rw_drained", 128'(occupancy), 128'd0);

        // Mid-stream asynchronous reset with occupancy 5
        fiu_c0TxAlmFull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            afu_c0Tx = mk_req(1'b0, 4'h3, 42'h4000 + 42'(i), 16'h300 + 16'(i));
            step();
        end
        afu_c0Tx = '0;
        check("mid_occ5", 128'(occupancy), 128'd5);
        fiu_c0TxAlmFull = 1'b0;
        step();
        check("mid_pre_out", 128'(fiu_c0Tx), 128'(mk_out(4'h3, 42'h4000, 16'h300)));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_fiu", 128'(fiu_c0Tx), 128'd0);
        check("mid_rst_occ", 128'(occupancy), 128'd0);
        check("mid_rst_flags", 128'({err_virtAddr, err_overflow, afu_c0TxAlmFull}), 128'd0);
        check("mid_rst_drops", 128'(drop_count), 128'd0);
        step();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post_rst_idle_%0d", i), 128'({fiu_c0Tx[0], occupancy}), 128'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
